// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream adapter and its skid buffer.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH          = 2;
  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef logic [1:0] level_t;

  // Stream beat kept here so the write-side adapter can share it.
  typedef struct packed {
    logic                          valid;
    logic [DATA_WIDTH_DEFAULT-1:0] data;
  } beat_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer: in-order capture behind held words, pop from the head, flush.
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  input  logic                  flush,
  output level_t                count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] buf0_r, buf1_r, buf0_s, buf1_s;
  level_t                count_r, count_s, wr_idx_s;

  // Next buffer contents and occupancy from capture/pop/flush.
  always_comb begin
    buf0_s   = buf0_r;
    buf1_s   = buf1_r;
    count_s  = count_r;
    wr_idx_s = count_r - {1'b0, pop};
    if (flush) begin
      count_s = 2'd0;
    end else begin
      if (pop) begin
        buf0_s = buf1_r;
      end else begin
        buf0_s = buf0_r;
      end
      // New word lands behind whatever survives this cycle's pop.
      if (capture) begin
        case (wr_idx_s)
          2'd0:    buf0_s = wdata;
          2'd1:    buf1_s = wdata;
          default: buf1_s = buf1_r;
        endcase
      end else begin
        buf1_s = buf1_r;
      end
      count_s = count_r + {1'b0, capture} - {1'b0, pop};
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_r  <= '0;
      buf1_r  <= '0;
      count_r <= 2'd0;
    end else begin
      buf0_r  <= buf0_s;
      buf1_r  <= buf1_s;
      count_r <= count_s;
    end
  end

  assign count = count_r;
  assign head  = buf0_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-port drainer presenting a first-word-fall-through valid/ready stream.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic                  o_fifo_rd,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  input  logic                  i_fifo_empty,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [1:0]            o_level
);

  level_t     count_s;
  logic       inflight_r;
  logic       pop_s;
  logic       capture_s;
  logic       rd_s;
  logic [2:0] committed_s;

  assign o_valid   = (count_s != 2'd0);
  assign pop_s     = o_valid & i_ready;
  assign capture_s = inflight_r & ~i_flush;

  // Issue only when the in-flight word is guaranteed a slot after this cycle's pop.
  always_comb begin
    committed_s = {1'b0, count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (i_rst || i_fifo_empty || i_flush) begin
      rd_s = 1'b0;
    end else begin
      rd_s = (committed_s < 3'(BUF_DEPTH));
    end
  end

  // Tracks the read whose data arrives next cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= rd_s;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk     (i_clk),
    .rst     (i_rst),
    .capture (capture_s),
    .wdata   (i_fifo_rdata),
    .pop     (pop_s),
    .flush   (i_flush),
    .count   (count_s),
    .head    (o_data)
  );

  assign o_fifo_rd = rd_s;
  assign o_level   = count_s;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_rd;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       flush;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic [1:0] level;

  logic [7:0] mem [0:63];
  logic [5:0] wr_ptr = 6'd0;
  logic [5:0] rd_ptr = 6'd0;
  int         reads = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         reads_base;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_fifo_rd    (fifo_rd),
    .i_fifo_rdata (fifo_rdata),
    .i_fifo_empty (fifo_empty),
    .i_flush      (flush),
    .o_valid      (valid),
    .o_data       (data),
    .i_ready      (ready),
    .o_level      (level)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);

  // FIFO model; its reset discards unread words.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= wr_ptr;
      fifo_rdata <= 8'h00;
    end else if (fifo_rd) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 6'd1;
      reads      <= reads + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr      = wr_ptr + 6'd1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  logic [6:0] rd2_e, val2_e;
  logic [7:0] w2 [0:3];
  logic [5:0] lvl3_e [0:5];

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    ready = 1'b0;
    repeat (2) next_cycle();
    #1;
    chk("rst_data", {24'd0, data}, 32'h0);
    chk("rst_level", {30'd0, level}, 32'd0);
    rst = 1'b0;

    // 1: idle with empty FIFO
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_rd", {31'd0, fifo_rd}, 32'd0);
      chk("idle_valid", {31'd0, valid}, 32'd0);
      chk("idle_level", {30'd0, level}, 32'd0);
      next_cycle();
    end

    // 2: four words, sink always ready
    rd2_e  = 7'b0001111;
    val2_e = 7'b0111100;
    w2[0] = 8'hA1; w2[1] = 8'hB2; w2[2] = 8'hC3; w2[3] = 8'hD4;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) push(w2[i]);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("t2_rd", {31'd0, fifo_rd}, {31'd0, rd2_e[i]});
      chk("t2_valid", {31'd0, valid}, {31'd0, val2_e[i]});
      chk("t2_level", {30'd0, level}, {31'd0, val2_e[i]});
      if (val2_e[i]) chk("t2_data", {24'd0, data}, {24'd0, w2[i-2]});
      next_cycle();
    end

    // 3: five words, sink stalled then released
    ready      = 1'b0;
    reads_base = reads;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    #1;
    chk("t3_rd0", {31'd0, fifo_rd}, 32'd1);
    next_cycle(); #1;
    chk("t3_rd1", {31'd0, fifo_rd}, 32'd1);
    next_cycle(); #1;
    chk("t3_rd2", {31'd0, fifo_rd}, 32'd0);
    next_cycle(); #1;
    chk("t3_rd3", {31'd0, fifo_rd}, 32'd0);
    next_cycle(); #1;
    chk("t3_reads", reads - reads_base, 32'd2);
    chk("t3_full_level", {30'd0, level}, 32'd2);
    chk("t3_hold_data", {24'd0, data}, 32'h10);
    lvl3_e[0] = 6'd2; lvl3_e[1] = 6'd1; lvl3_e[2] = 6'd1;
    lvl3_e[3] = 6'd1; lvl3_e[4] = 6'd1; lvl3_e[5] = 6'd0;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk(i == 1 ? "t4_level" : "t3_level", {30'd0, level}, {26'd0, lvl3_e[i]});
      chk("t3_valid", {31'd0, valid}, (i < 5) ? 32'd1 : 32'd0);
      if (i < 5) chk("t3_data", {24'd0, data}, 32'h10 + 32'(i));
      next_cycle();
    end

    // 5: flush with one word buffered and one in flight
    ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    repeat (3) next_cycle();
    ready = 1'b1;
    #1;
    chk("t5_pre_level", {30'd0, level}, 32'd2);
    chk("t5_pre_data", {24'd0, data}, 32'h20);
    next_cycle();
    ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("t5_flush_data", {24'd0, data}, 32'h21);
    chk("t5_flush_level", {30'd0, level}, 32'd1);
    chk("t5_flush_rd", {31'd0, fifo_rd}, 32'd0);
    next_cycle();
    flush = 1'b0;
    #1;
    chk("t5_post_level", {30'd0, level}, 32'd0);
    chk("t5_post_valid", {31'd0, valid}, 32'd0);
    chk("t5_post_rd", {31'd0, fifo_rd}, 32'd1);
    next_cycle(); #1;
    chk("t5_wait_valid", {31'd0, valid}, 32'd0);
    chk("t5_wait_rd", {31'd0, fifo_rd}, 32'd0);
    next_cycle(); #1;
    chk("t5_next_valid", {31'd0, valid}, 32'd1);
    chk("t5_next_data", {24'd0, data}, 32'h23);
    chk("t5_next_level", {30'd0, level}, 32'd1);
    ready = 1'b1;
    next_cycle(); #1;
    chk("t5_drain_valid", {31'd0, valid}, 32'd0);
    next_cycle();

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    next_cycle(); next_cycle(); #1;
    chk("t6_pre_valid", {31'd0, valid}, 32'd1);
    chk("t6_pre_data", {24'd0, data}, 32'h30);
    chk("t6_pre_rd", {31'd0, fifo_rd}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, valid}, 32'd0);
    chk("t6_rst_rd", {31'd0, fifo_rd}, 32'd0);
    chk("t6_rst_level", {30'd0, level}, 32'd0);
    next_cycle(); #1;
    chk("t6_hold_level", {30'd0, level}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      chk("t6_after_valid", {31'd0, valid}, 32'd0);
      chk("t6_after_rd", {31'd0, fifo_rd}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
